// File: rtl/bch_data_correct.sv
// BCH error-application stage: buffers the data part of a codeword, then XORs the
// Chien error stream onto it beat by beat and emits corrected data with framing.
module bch_data_correct #(
  parameter int unsigned DATA_BITS = 4,
  parameter int unsigned BITS      = 1,
  localparam int unsigned CNT_W    = $clog2(DATA_BITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_start,
  input  logic             in_valid,
  input  logic [BITS-1:0]  in_data,
  output logic             in_ready,
  input  logic             err_first,
  input  logic             err_valid,
  input  logic [BITS-1:0]  err,
  output logic             out_valid,
  output logic             out_first,
  output logic             out_last,
  output logic [BITS-1:0]  out_data,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_orphan
);

  localparam int unsigned BEATS = DATA_BITS / BITS;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FILL    = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;
  localparam logic [1:0] CORRECT = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [BITS-1:0] data_buf [BEATS];

  logic            wr_en;
  logic [CW-1:0]   wr_idx;
  logic            hit;
  logic [CW-1:0]   rd_idx;
  logic            orphan;

  function automatic logic [CNT_W-1:0] popcount(input logic [BITS-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(BITS); i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  // Next-state decode: buffer writes, error-beat acceptance and orphan detection.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    wr_en    = 1'b0;
    wr_idx   = wr_cnt_q;
    hit      = 1'b0;
    rd_idx   = rd_cnt_q;
    orphan   = 1'b0;
    unique case (state_q)
      IDLE, FILL: begin
        // in_start always (re)starts the word at beat 0
        if (in_start) begin
          wr_en    = 1'b1;
          wr_idx   = '0;
          wr_cnt_d = CW'(1);
          state_d  = (BEATS == 1) ? HOLD : FILL;
        end else if (in_valid && state_q == FILL) begin
          wr_en    = 1'b1;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == LAST) state_d = HOLD;
        end
        orphan = err_first;
      end
      HOLD: begin
        if (err_first) begin
          hit    = 1'b1;
          rd_idx = '0;
        end
      end
      CORRECT: begin
        // a second err_first mid-word belongs to no stored word
        if (err_first) orphan = 1'b1;
        else if (err_valid) hit = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (hit) begin
      rd_cnt_d = rd_idx + 1'b1;
      state_d  = (rd_idx == LAST) ? IDLE : CORRECT;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      err_cnt    <= '0;
      err_orphan <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      in_ready   <= (state_d == IDLE) || (state_d == FILL);
      out_valid  <= hit;
      out_first  <= hit && (state_q == HOLD);
      out_last   <= hit && (rd_idx == LAST);
      err_orphan <= orphan;
      if (hit) begin
        out_data <= data_buf[rd_idx] ^ err;
        err_cnt  <= ((state_q == HOLD) ? '0 : err_cnt) + popcount(err);
      end
    end
  end

  // Data buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) data_buf[wr_idx] <= in_data;
  end

endmodule

// File: tb/tb_bch_data_correct.sv
// Directed bench for bch_data_correct: a 4x1-bit instance and an 8-bit/4-bit-beat instance,
// checked every cycle against a word-level expectation queue plus literal results.
module tb_bch_data_correct;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int         due;
    logic [3:0] data;
    logic       first;
    logic       last;
    int         cnt;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   oa[$];
  int   ob[$];

  logic [3:0] got_a     = '0;
  int         got_cnt_a = 0;
  logic [7:0] got_b     = '0;
  int         got_cnt_b = 0;

  // Instance A: DATA_BITS=4, BITS=1
  logic       rst_a = 1'b0;
  logic       a_in_start = 0, a_in_valid = 0, a_in_data = 0;
  logic       a_err_first = 0, a_err_valid = 0, a_err = 0;
  logic       a_in_ready, a_out_valid, a_out_first, a_out_last, a_out_data, a_err_orphan;
  logic [2:0] a_err_cnt;

  bch_data_correct #(.DATA_BITS(4), .BITS(1)) dut_a (
    .clk(clk), .rst(rst_a),
    .in_start(a_in_start), .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .err_first(a_err_first), .err_valid(a_err_valid), .err(a_err),
    .out_valid(a_out_valid), .out_first(a_out_first), .out_last(a_out_last),
    .out_data(a_out_data), .err_cnt(a_err_cnt), .err_orphan(a_err_orphan)
  );

  // Instance B: DATA_BITS=8, BITS=4
  logic       rst_b = 1'b0;
  logic       b_in_start = 0, b_in_valid = 0;
  logic [3:0] b_in_data = '0;
  logic       b_err_first = 0, b_err_valid = 0;
  logic [3:0] b_err = '0;
  logic       b_in_ready, b_out_valid, b_out_first, b_out_last, b_err_orphan;
  logic [3:0] b_out_data;
  logic [3:0] b_err_cnt;

  bch_data_correct #(.DATA_BITS(8), .BITS(4)) dut_b (
    .clk(clk), .rst(rst_b),
    .in_start(b_in_start), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .err_first(b_err_first), .err_valid(b_err_valid), .err(b_err),
    .out_valid(b_out_valid), .out_first(b_out_first), .out_last(b_out_last),
    .out_data(b_out_data), .err_cnt(b_err_cnt), .err_orphan(b_err_orphan)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare for A against the expectation queues.
  always @(negedge clk) begin : cmp_a
    exp_t x;
    if (qa.size() > 0 && qa[0].due == cyc) begin
      x = qa.pop_front();
      check("a_out_valid", a_out_valid, 1);
      check("a_out_data", a_out_data, x.data[0]);
      check("a_out_first", a_out_first, x.first);
      check("a_out_last", a_out_last, x.last);
      check("a_err_cnt", a_err_cnt, x.cnt);
      got_a = {got_a[2:0], a_out_data};
      if (x.last) got_cnt_a = a_err_cnt;
    end else begin
      check("a_out_valid_idle", a_out_valid, 0);
    end
    if (oa.size() > 0 && oa[0] == cyc) begin
      void'(oa.pop_front());
      check("a_err_orphan", a_err_orphan, 1);
    end else begin
      check("a_err_orphan_idle", a_err_orphan, 0);
    end
  end

  // Per-cycle compare for B against the expectation queues.
  always @(negedge clk) begin : cmp_b
    exp_t x;
    if (qb.size() > 0 && qb[0].due == cyc) begin
      x = qb.pop_front();
      check("b_out_valid", b_out_valid, 1);
      check("b_out_data", b_out_data, x.data);
      check("b_out_first", b_out_first, x.first);
      check("b_out_last", b_out_last, x.last);
      check("b_err_cnt", b_err_cnt, x.cnt);
      got_b = {got_b[3:0], b_out_data};
      if (x.last) got_cnt_b = b_err_cnt;
    end else begin
      check("b_out_valid_idle", b_out_valid, 0);
    end
    if (ob.size() > 0 && ob[0] == cyc) begin
      void'(ob.pop_front());
      check("b_err_orphan", b_err_orphan, 1);
    end else begin
      check("b_err_orphan_idle", b_err_orphan, 0);
    end
  end

  task automatic a_drive(input logic st, input logic iv, input logic d,
                         input logic ef, input logic ev, input logic e);
    @(posedge clk);
    #1;
    a_in_start = st; a_in_valid = iv; a_in_data = d;
    a_err_first = ef; a_err_valid = ev; a_err = e;
  endtask

  task automatic a_idle(input int n);
    for (int k = 0; k < n; k++) a_drive(0, 0, 0, 0, 0, 0);
  endtask

  // Data beat 0 is d[3]; error beat 0 is e[3].
  task automatic a_word(input logic [3:0] d, input logic [3:0] e, input int junk,
                        input int orph_after, input int gap_after, input int hold,
                        input bit tail);
    exp_t x;
    int   cnt;
    cnt = 0;
    for (int j = 0; j < junk; j++) a_drive(j == 0, j != 0, 1'b1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      a_drive(i == 0, i != 0, d[3-i], 0, 0, 0);
      if (i == 0) check("a_in_ready_fill", a_in_ready, 1);
      if (i == orph_after) begin
        a_drive(0, 0, 0, 1, 0, 1);
        oa.push_back(cyc + 1);
      end
    end
    for (int h = 0; h < hold; h++) a_idle(1);
    for (int i = 0; i < 4; i++) begin
      a_drive(0, 0, 0, i == 0, i != 0, e[3-i]);
      if (i == 0) check("a_in_ready_hold", a_in_ready, 0);
      cnt += int'(e[3-i]);
      x.due = cyc + 1; x.data = {3'b0, d[3-i] ^ e[3-i]};
      x.first = (i == 0); x.last = (i == 3); x.cnt = cnt;
      qa.push_back(x);
      if (i == gap_after) a_idle(3);
    end
    if (tail) a_idle(2);
  endtask

  task automatic b_drive(input logic st, input logic iv, input logic [3:0] d,
                         input logic ef, input logic ev, input logic [3:0] e);
    @(posedge clk);
    #1;
    b_in_start = st; b_in_valid = iv; b_in_data = d;
    b_err_first = ef; b_err_valid = ev; b_err = e;
  endtask

  task automatic b_idle(input int n);
    for (int k = 0; k < n; k++) b_drive(0, 0, 4'h0, 0, 0, 4'h0);
  endtask

  // Full 2-beat word when nerr=2; nerr=1 sends only the first error beat.
  task automatic b_word(input logic [7:0] d, input logic [7:0] e, input int nerr);
    exp_t       x;
    int         cnt;
    logic [3:0] db, eb;
    cnt = 0;
    b_drive(1, 0, d[7:4], 0, 0, 4'h0);
    check("b_in_ready_fill", b_in_ready, 1);
    b_drive(0, 1, d[3:0], 0, 0, 4'h0);
    b_idle(1);
    for (int i = 0; i < nerr; i++) begin
      db = (i == 0) ? d[7:4] : d[3:0];
      eb = (i == 0) ? e[7:4] : e[3:0];
      b_drive(0, 0, 4'h0, i == 0, i != 0, eb);
      cnt += $countones(eb);
      x.due = cyc + 1; x.data = db ^ eb;
      x.first = (i == 0); x.last = (i == 1); x.cnt = cnt;
      qb.push_back(x);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state of both instances
    repeat (3) @(posedge clk);
    #1;
    check("a_rst_in_ready", a_in_ready, 0);
    check("a_rst_out_valid", a_out_valid, 0);
    check("a_rst_out_data", a_out_data, 0);
    check("a_rst_err_cnt", a_err_cnt, 0);
    check("b_rst_in_ready", b_in_ready, 0);
    check("b_rst_out_data", b_out_data, 0);
    check("b_rst_err_cnt", b_err_cnt, 0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    check("a_in_ready_after_rst", a_in_ready, 1);
    check("b_in_ready_after_rst", b_in_ready, 1);

    // Basic word: 1,1,0,0 with errors 0,1,0,0
    a_word(4'b1100, 4'b0100, 0, -1, -1, 2, 1);
    check("a_word1_out", got_a, 4'b1000);
    check("a_word1_cnt", got_cnt_a, 1);
    a_idle(2);
    check("a_word1_cnt_held", a_err_cnt, 1);

    // Zero-error word, then a back-to-back word started right after out_last
    a_word(4'b1011, 4'b0000, 0, -1, -1, 1, 0);
    a_word(4'b0110, 4'b1001, 0, -1, -1, 0, 1);
    check("a_b2b_out", got_a, 4'b1111);
    check("a_b2b_cnt", got_cnt_a, 2);

    // Orphan in IDLE, then orphan in FILL after two beats
    a_drive(0, 0, 0, 1, 0, 1);
    oa.push_back(cyc + 1);
    a_idle(2);
    check("a_idle_in_ready", a_in_ready, 1);
    a_word(4'b0101, 4'b0010, 0, 1, -1, 1, 1);
    check("a_orphan_word_out", got_a, 4'b0111);
    check("a_orphan_word_cnt", got_cnt_a, 1);

    // Restart after two beats
    a_word(4'b0011, 4'b1111, 2, -1, -1, 1, 1);
    check("a_restart_out", got_a, 4'b1100);
    check("a_restart_cnt", got_cnt_a, 4);

    // Gapped error stream between beats 1 and 2
    a_word(4'b1101, 4'b0110, 0, -1, 1, 1, 1);
    check("a_gap_out", got_a, 4'b1011);
    check("a_gap_cnt", got_cnt_a, 2);

    // Wide beats: A,5 with errors 1,8
    b_word(8'hA5, 8'h18, 2);
    b_idle(2);
    check("b_word_out", got_b, 8'hBD);
    check("b_word_cnt", got_cnt_b, 2);

    // Reset mid-CORRECT: only beat 0 emerges
    b_word(8'hA5, 8'h30, 1);
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    b_in_start = 0; b_in_valid = 0; b_err_first = 0; b_err_valid = 1; b_err = 4'hF;
    b_idle(1);
    check("b_in_ready_in_rst", b_in_ready, 0);
    check("b_err_cnt_in_rst", b_err_cnt, 0);
    rst_b = 1'b1;
    b_idle(1);
    check("b_in_ready_post_rst", b_in_ready, 1);
    b_idle(3);
    b_word(8'h3C, 8'h0F, 2);
    b_idle(2);
    check("b_post_rst_out", got_b, 8'h33);
    check("b_post_rst_cnt", got_cnt_b, 4);

    a_idle(2);
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    check("a_orphan_drained", oa.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bch_data_correct.md
# bch_data_correct

Error-application stage of the BCH decode path, directly downstream of the Chien search (error locator plus Chien counter). It captures the data portion of a received codeword while that codeword streams into the syndrome unit. It then holds the data through syndrome and key-equation latency. When the Chien error stream arrives, it XORs each error beat onto the matching stored data beat and emits corrected data with framing and a corrected-bit count.

## Interface
- DATA_BITS, 4, data bits per codeword (k); must be a multiple of BITS
- BITS, 1, bits per beat on every stream; BEATS = DATA_BITS/BITS
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- in_start  in  1  marks first data beat of a codeword; is itself a valid beat
- in_valid  in  1  data beat present (continuation beats)
- in_data  in  BITS  received data beat
- in_ready  out  1  block accepts data beats
- err_first  in  1  first Chien error beat; is itself a valid beat
- err_valid  in  1  continuation error beat
- err  in  BITS  error mask beat, 1 = flip
- out_valid  out  1  corrected beat present
- out_first  out  1  first corrected beat
- out_last  out  1  last corrected beat
- out_data  out  BITS  corrected beat
- err_cnt  out  $clog2(DATA_BITS+1)  bits flipped in the current word; final at out_last
- err_orphan  out  1  one-cycle pulse when an error stream is not matched to a stored word

## Operation
- Beat order: error beat n corrects data beat n (0..BEATS-1), bitwise same position.
- States: IDLE, FILL, HOLD, CORRECT.
- IDLE: in_ready=1. A cycle with in_start writes beat 0, sets wr_cnt=1, and moves to FILL. If BEATS==1, it moves to HOLD instead. in_valid without in_start is ignored.
- FILL: in_ready=1. Each in_valid writes a beat at index wr_cnt.
  - When the beat at index BEATS-1 is written, the state moves to HOLD.
  - in_start in FILL restarts the word: the beat goes to index 0 and wr_cnt=1.
- HOLD: in_ready=0 and the buffer is full. Any err_first starts CORRECT with rd_cnt=0 and err_cnt cleared. err_valid without err_first is ignored.
- CORRECT: each accepted error beat (err_first on entry, then err_valid) produces a registered output:
  - out_data = buf[rd_cnt] ^ err
  - err_cnt += popcount(err)
  - rd_cnt increments
  - The beat at rd_cnt==BEATS-1 drives out_last and returns the state to IDLE.
- Gaps in err_valid are allowed; out_valid follows with a one-cycle delay. Output has no backpressure.
- err_orphan: pulses for err_first in IDLE, FILL, or CORRECT. The error beat is discarded and state is unchanged.
- err_valid in IDLE or FILL is ignored silently. This covers stray trailing beats after a word completes.
- err_first and err_valid in the same cycle count as a single beat.

## Timing
- Reset: state=IDLE, in_ready=1 (the cycle after rst deasserts, since outputs are registered; during reset it is 0), out_valid=out_first=out_last=0, out_data=0, err_cnt=0, err_orphan=0, and counters are 0. Buffer contents are don't-care.
- Reset mid-operation discards the stored word and any in-progress output; no out_last is produced.
- All outputs are registered.
- The last data beat accepted at cycle t gives in_ready=0 from t+1.
- An error beat accepted at cycle t gives the matching out_* at t+1.
- The final error beat at t gives out_last at t+1, with state=IDLE and in_ready=1 at t+1. A new in_start is accepted at t+1.
- Throughput: one beat per cycle on both sides. Minimum word period is 2·BEATS cycles plus upstream decode latency.
- out_first and out_last are both asserted on the single beat when BEATS==1.
- err_cnt holds its value after out_last until the next err_first in HOLD.

## Test plan
- DATA_BITS=4, BITS=1: data beats 1,1,0,0; error beats 0,1,0,0 -> out beats 1,0,0,0, out_first on beat 0, out_last on beat 3, err_cnt=1.
- Zero-error word: data 1,0,1,1 and error beats all 0 -> out 1,0,1,1 and err_cnt=0. Then a back-to-back second word with in_start the cycle after out_last is accepted.
- Orphan: err_first in IDLE -> err_orphan pulses for 1 cycle, out_valid stays 0, state stays IDLE. Repeat the check in FILL after 2 beats; the partial word is preserved and completes normally.
- Restart: in_start, 2 beats, then in_start again with 4 beats 0,0,1,1; errors 1,1,1,1 -> out 1,1,0,0 and err_cnt=4.
- Gapped error stream: err_valid deasserted for 3 cycles between beats 1 and 2 -> out_valid gaps match, data is correct, and out_last is asserted only on beat 3.
- DATA_BITS=8, BITS=4: data 4'hA then 4'h5; errors 4'h1 then 4'h8 -> out 4'hB then 4'hD, err_cnt=2. Assert rst low mid-CORRECT -> no further out_valid and in_ready=1 after release.
